// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command-frame parser.
// Contents:
//   - parse_state_t : frame assembly FSM encoding (3-bit, IDLE = 0)
//   - ERR_*         : error codes reported on err_code
//   - DEFAULT_SYNC_BYTE : default frame start marker
//   - frame_chk()   : 8-bit XOR checksum over CMD, ARG_HI, ARG_LO
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_HI  = 3'd2,
        GET_LO  = 3'd3,
        GET_CHK = 3'd4
    } parse_state_t;

    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] hi,
                                             input logic [7:0] lo);
        return cmd ^ hi ^ lo;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bundle of the parser's data-path signals.
//   rx_ready/rx_data : byte stream from the UART receiver
//   valid/ready      : command handshake toward the playback controller
//   cmd/arg          : decoded opcode and 16-bit argument
//   err/err_code     : one-cycle error pulse and last error code
// The master modport is the parser side; slave is its environment.
interface uart_cmd_parser_if;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        valid;
    logic        ready;
    logic [7:0]  cmd;
    logic [15:0] arg;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        input  rx_ready, rx_data, ready,
        output valid, cmd, arg, err, err_code
    );

    modport slave (
        output rx_ready, rx_data, ready,
        input  valid, cmd, arg, err, err_code
    );
endinterface

// File: rtl/uart_cmd_parser_rise_edge_detect.sv
// Rising-edge detector: pulse is high for the single cycle in which din
// is high while its registered copy is still low.
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : level input
//   pulse      : one-cycle pulse on each 0->1 transition of din
// RESET_VAL sets the remembered level after reset; a value of 1 means an
// input that is already high when reset releases does not produce a pulse.
module rise_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);
    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_q <= RESET_VAL;
        else        din_q <= din;
    end

    assign pulse = din && !din_q;
endmodule

// File: rtl/uart_cmd_parser.sv
// UART command-frame parser. Assembles SYNC, CMD, ARG_HI, ARG_LO, CHK
// frames from the receiver byte stream, validates the XOR checksum,
// enforces an inter-byte timeout and offers good commands on valid/ready.
//   clk   : system clock (CLOCK_RATE Hz)
//   rst_n : asynchronous active-low reset
//   bus   : uart_cmd_parser_if.master (receiver in, command/error out)
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         CLOCK_RATE   = 48000000,
    parameter int         BAUD_RATE    = 9600,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = (CLOCK_RATE / BAUD_RATE) * 20
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_cmd_parser_if.master   bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    parse_state_t     state_reg, state_next;
    logic             strobe;
    logic [7:0]       cmd_sh_reg, hi_sh_reg, lo_sh_reg;
    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             valid_reg, err_reg;
    logic [7:0]       cmd_reg;
    logic [15:0]      arg_reg;
    logic [1:0]       err_code_reg;

    logic             timeout_hit, chk_byte, chk_match, out_free;
    logic             load_out, overrun, chk_err;

    // Ready may stay high for many cycles per byte; only its rising edge
    // counts as a byte.
    rise_edge_detect #(.RESET_VAL(1'b1)) u_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.rx_ready),
        .pulse (strobe)
    );

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_hit = (state_reg != IDLE) && !strobe && (tmo_cnt_reg == CNT_LAST);

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_next = state_reg;
        if (timeout_hit) begin
            state_next = IDLE;
        end else if (strobe) begin
            unique case (state_reg)
                IDLE:    if (bus.rx_data == SYNC_BYTE) state_next = GET_CMD;
                GET_CMD: state_next = GET_HI;
                GET_HI:  state_next = GET_LO;
                GET_LO:  state_next = GET_CHK;
                GET_CHK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ---- FSM: outputs / events ----
    always_comb begin
        chk_byte  = strobe && (state_reg == GET_CHK);
        chk_match = bus.rx_data == frame_chk(cmd_sh_reg, hi_sh_reg, lo_sh_reg);
        // The output slot is free if empty or being drained this cycle.
        out_free  = !valid_reg || bus.ready;
        load_out  = chk_byte && chk_match && out_free;
        overrun   = chk_byte && chk_match && !out_free;
        chk_err   = chk_byte && !chk_match;
    end

    // Shadow capture of frame body bytes and the inter-byte timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_sh_reg  <= '0;
            hi_sh_reg   <= '0;
            lo_sh_reg   <= '0;
            tmo_cnt_reg <= '0;
        end else begin
            if (strobe && state_reg == GET_CMD) cmd_sh_reg <= bus.rx_data;
            if (strobe && state_reg == GET_HI)  hi_sh_reg  <= bus.rx_data;
            if (strobe && state_reg == GET_LO)  lo_sh_reg  <= bus.rx_data;

            if (state_reg == IDLE || strobe || timeout_hit) tmo_cnt_reg <= '0;
            else                                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    // Registered command output and error reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= 1'b0;
            cmd_reg      <= '0;
            arg_reg      <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= '0;
        end else begin
            if (load_out) begin
                valid_reg <= 1'b1;
                cmd_reg   <= cmd_sh_reg;
                arg_reg   <= {hi_sh_reg, lo_sh_reg};
            end else if (valid_reg && bus.ready) begin
                valid_reg <= 1'b0;
            end

            // chk_err/overrun need a strobe and timeout_hit needs none, so
            // at most one of them is set in any cycle.
            err_reg <= chk_err || overrun || timeout_hit;
            if (chk_err)          err_code_reg <= ERR_CHECKSUM;
            else if (overrun)     err_code_reg <= ERR_OVERRUN;
            else if (timeout_hit) err_code_reg <= ERR_TIMEOUT;
        end
    end

    assign bus.valid    = valid_reg;
    assign bus.cmd      = cmd_reg;
    assign bus.arg      = arg_reg;
    assign bus.err      = err_reg;
    assign bus.err_code = err_code_reg;
endmodule
